// File: rtl/relu_maxpool_22_pkg.sv
// Shared definitions for the ReLU + 2x2 max-pool stage.
//   DEFAULT_DATA_WIDTH : binary32 pixel width
//   FP_SIGN_BIT        : sign bit position for the default width
//   row_state_e        : row-parity state, encoding shared with other pooling stages
package relu_maxpool_22_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int FP_SIGN_BIT        = DEFAULT_DATA_WIDTH - 1;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;
endpackage

// File: rtl/relu_maxpool_22_line_buf.sv
// pool_line_buf: one-row buffer of horizontal pair maxima.
// Synchronous write, combinational read, single shared address port.
//   clk     : clock
//   i_we    : write enable
//   i_addr  : entry address (write and read)
//   i_wdata : write data
//   o_rdata : read data at i_addr
// Contents are intentionally not reset; every entry is written on an even
// row before it is read on the following odd row.
module pool_line_buf #(
  parameter int DEPTH      = 110,
  parameter int AW         = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/relu_maxpool_22.sv
// relu_maxpool_22: ReLU followed by 2x2 stride-2 max-pool over a D x D
// raster stream of binary32 pixels; emits a (D/2) x (D/2) raster stream.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   valid_in   : pxl_in valid (gaps allowed, no backpressure)
//   pxl_in     : input pixel, raster order
//   pxl_out    : pooled pixel, held between valid_out pulses
//   valid_out  : one-cycle qualifier for pxl_out
//   frame_done : one-cycle pulse with the last pooled pixel of a frame
module relu_maxpool_22
  import relu_maxpool_22_pkg::*;
#(
  parameter int D          = 220,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);
  localparam int              CW   = (D > 2) ? $clog2(D) : 1;
  localparam int              AW   = (D > 2) ? $clog2(D / 2) : 1;
  localparam int              SIGN = DATA_WIDTH - 1;
  localparam logic [CW-1:0]   LAST = CW'(D - 1);

  logic [CW-1:0]         r_col, r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  row_state_e            r_state, w_state_nxt;

  logic                  w_col_wrap, w_row_wrap;
  logic [DATA_WIDTH-1:0] w_relu, w_pair_max, w_lb_rd, w_pool_max;
  logic                  w_lb_we, w_out_fire, w_frame_fire;
  logic [AW-1:0]         w_addr;

  // Negative inputs (incl. -0.0 and negative NaN) clamp to +0. Afterwards
  // every word has sign 0, so an unsigned word compare is a float max;
  // a positive NaN wins and propagates.
  assign w_relu     = pxl_in[SIGN] ? '0 : pxl_in;
  assign w_pair_max = (r_pair > w_relu) ? r_pair : w_relu;
  assign w_pool_max = (w_lb_rd > w_pair_max) ? w_lb_rd : w_pair_max;

  assign w_col_wrap = (r_col == LAST);
  assign w_row_wrap = (r_row == LAST);
  assign w_addr     = AW'(r_col >> 1);

  pool_line_buf #(
    .DEPTH     (D / 2),
    .AW        (AW),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_line_buf (
    .clk    (clk),
    .i_we   (w_lb_we),
    .i_addr (w_addr),
    .i_wdata(w_pair_max),
    .o_rdata(w_lb_rd)
  );

  // Row-parity FSM: even rows fill the line buffer, odd rows finish blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ROW_EVEN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lb_we      = 1'b0;
    w_out_fire   = 1'b0;
    w_frame_fire = 1'b0;
    if (valid_in) begin
      if (w_col_wrap) w_state_nxt = (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      if (r_col[0]) begin
        case (r_state)
          ROW_EVEN: w_lb_we = 1'b1;
          ROW_ODD: begin
            w_out_fire   = 1'b1;
            w_frame_fire = w_row_wrap & w_col_wrap;
          end
          default: ;
        endcase
      end
    end
  end

  // Raster position counters, pair register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pair     <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= w_out_fire;
      frame_done <= w_frame_fire;
      if (w_out_fire) pxl_out <= w_pool_max;
      if (valid_in) begin
        if (!r_col[0]) r_pair <= w_relu;
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/relu_maxpool_22.md
# relu_maxpool_22

Post-convolution stage that consumes the raster pixel stream produced by the 7x1 convolution (pxl_out/valid_out). It applies ReLU and a 2x2 max-pool with stride 2 to a D x D frame of IEEE-754 single-precision values and emits a (D/2) x (D/2) raster stream. It is the next stage in the convolution pipeline, ahead of the following layer's frame buffer.

## Interface
- D, 220, input frame width and height in pixels; must be even and at least 2.
- DATA_WIDTH, 32, pixel width in bits; IEEE-754 binary32, sign bit at DATA_WIDTH-1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  pxl_in carries a valid pixel this cycle; may deassert at any time (gaps allowed).
- pxl_in  in  DATA_WIDTH  input pixel, raster order: row 0 col 0 first.
- pxl_out  out  DATA_WIDTH  pooled pixel; 0 in reset.
- valid_out  out  1  single-cycle qualifier for pxl_out; 0 in reset.
- frame_done  out  1  one-cycle pulse coincident with the last pooled pixel of a frame; 0 in reset.

## Operation
- ReLU: if pxl_in[DATA_WIDTH-1] is 1 (any negative value, including -0.0 and negative NaN), the value is 0; otherwise it passes unchanged.
- After ReLU, all values have sign 0, so max is an unsigned compare on the full word. A positive NaN compares as larger than any finite value and propagates; this is accepted behaviour.
- Counters: col (0..D-1) and row (0..D-1) advance only on accepted pixels (valid_in=1). col wraps to 0 at D-1, and row increments then. row wraps to 0 at D-1 when col also wraps, which starts a new frame.
- Pair register: on even col, hold the ReLU value in pair_r. On odd col, pair_max = max(pair_r, relu(pxl_in)).
- FSM with two states, ROW_EVEN and ROW_ODD. Reset state is ROW_EVEN. The state toggles on every col wrap.
- ROW_EVEN, odd col: linebuf[col>>1] <= pair_max. No output.
- ROW_ODD, odd col: pxl_out <= max(pair_max, linebuf[col>>1]) and valid_out <= 1. If row = D-1 and col = D-1, also frame_done <= 1.
- linebuf holds D/2 entries of DATA_WIDTH. It is written only in ROW_EVEN and read only in ROW_ODD, so a single read and write port suffices. Contents need not be reset.
- Output count per frame: exactly (D/2)^2 valid_out pulses, in pooled raster order.
- Back-to-back frames: there is no gap requirement. The first pixel after a frame wrap is row 0 col 0 of the next frame.
- Reset mid-frame: the counters, FSM, pair_r and the outputs return to their reset values. The next accepted pixel is treated as row 0 col 0. Stale linebuf contents are never read before being rewritten.

## Timing
- Latency: valid_out/pxl_out assert on the clock edge that accepts the odd-row, odd-col pixel. They are visible in the cycle after that acceptance.
- valid_out and frame_done are high for exactly one cycle per event. When no output event occurs, they are 0 even while valid_in is high.
- pxl_out holds its last value when valid_out=0. Consumers must qualify it with valid_out.
- Throughput: one input per cycle sustained, with no backpressure. The block never stalls.
- The input cadence matches the convolution stage exactly: valid_in high over a contiguous window with no internal bubbles is the common case, but gaps are legal.
- Asynchronous reset assertion clears the outputs immediately, without waiting for a clock edge. Deassertion is synchronised by the system, not by this block.

## Structure
- Shared package/header:
  - FP_SIGN_BIT (DATA_WIDTH-1);
  - the default DATA_WIDTH;
  - the state encodings ROW_EVEN=1'b0 and ROW_ODD=1'b1, shared with other pooling stages.
- Sub-module pool_line_buf: a D/2 x DATA_WIDTH synchronous-write, combinational-read array, with address width $clog2(D/2).
- The ReLU and max functions are inline combinational logic in the top module.

## Test plan
- D=4, ascending positive floats 1.0..16.0 streamed without gaps. Outputs, in order, are 6.0, 8.0, 14.0, 16.0. valid_out fires 4 times, and frame_done fires with 16.0.
- D=4, all inputs negative (e.g. -3.0, and one -0.0 = 0x80000000). All 4 outputs are 0x00000000.
- D=4, mixed signs: block 0 is {-5.0, 2.0, 0.5, -1.0}. First output is 2.0. A block with a single positive NaN 0x7FC00000 outputs 0x7FC00000.
- D=4, random valid_in gaps of 0-3 cycles between pixels. The outputs and counts are identical to the no-gap case, and each output appears the cycle after its triggering pixel.
- Two back-to-back D=4 frames with no idle cycle between them. There are 8 outputs, frame_done pulses twice, and the second frame's values are unaffected by the first.
- Assert reset after 6 pixels of a D=4 frame. The outputs go to 0 immediately. After release, a full fresh frame of 1.0..16.0 yields 6.0, 8.0, 14.0, 16.0 exactly.
